// File: rtl/accelerator_common_pkg.sv
// Shared types for the accelerator control path: scheduler states,
// descriptor layout and flag bit positions.
package accelerator_common_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LD_REQ,
    S_LD_WAIT,
    S_CMP,
    S_CMP_WAIT,
    S_ST_REQ,
    S_ST_WAIT,
    S_NEXT,
    S_DONE,
    S_ERR
  } sched_state_e;

  // Bit positions inside the 8-bit flags field (word0[23:16])
  localparam int unsigned FLAG_LOAD    = 0;
  localparam int unsigned FLAG_COMPUTE = 1;
  localparam int unsigned FLAG_STORE   = 2;
  localparam int unsigned FLAG_LAST    = 7;

  // Word indices of the descriptor fields (word0 is bits [31:0])
  localparam int unsigned WORD_CTRL   = 0;
  localparam int unsigned WORD_CFG_LO = 1;
  localparam int unsigned WORD_DST    = 2;
  localparam int unsigned WORD_CFG_HI = 5;
  localparam int unsigned WORD_SRAM   = 6;
  localparam int unsigned WORD_SRC    = 7;

  localparam int unsigned FLAGS_LSB = WORD_CTRL * 32 + 16;

  // Packed view of one 256-bit descriptor, MSB (word7) first
  typedef struct packed {
    logic [31:0] src_addr;   // word7
    logic [15:0] len;        // word6[31:16]
    logic [15:0] sram_addr;  // word6[15:0]
    logic [31:0] cfg_hi;     // word5
    logic [31:0] word4;
    logic [31:0] word3;
    logic [31:0] dst_addr;   // word2
    logic [31:0] cfg_lo;     // word1
    logic [7:0]  ctrl_hi;    // word0[31:24]
    logic [7:0]  flags;      // word0[23:16]
    logic [15:0] ctrl_lo;    // word0[15:0]
  } desc_t;

  // Next work stage of a tile once stage 'from' has finished
  function automatic sched_state_e route_after(input logic [7:0] flags,
                                               input sched_state_e from);
    sched_state_e nxt;
    nxt = S_NEXT;
    if (flags[FLAG_LOAD] && from == S_FETCH)
      nxt = S_LD_REQ;
    else if (flags[FLAG_COMPUTE] && (from == S_FETCH || from == S_LD_WAIT))
      nxt = S_CMP;
    else if (flags[FLAG_STORE])
      nxt = S_ST_REQ;
    return nxt;
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// Synchronous FIFO with full/empty flags, synchronous flush and
// asynchronous active-low reset. Head entry is visible on pop_data.
module desc_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage write; entries need no reset since empty gates every read
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Read/write pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Per-tile sequencer: pops descriptors and issues DMA load, compute start
// and DMA store in order, tracking status, tile and busy-cycle counters.
// DESC_WIDTH must match the 256-bit desc_t layout.
module tile_scheduler
  import accelerator_common_pkg::*;
#(
  parameter int unsigned DESC_WIDTH     = 256,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  soft_reset,
  input  logic                  desc_valid,
  input  logic [DESC_WIDTH-1:0] desc_data,
  output logic                  desc_ready,
  output logic                  dma_req_valid,
  input  logic                  dma_req_ready,
  output logic                  dma_req_write,
  output logic [31:0]           dma_req_dram_addr,
  output logic [15:0]           dma_req_sram_addr,
  output logic [15:0]           dma_req_len,
  input  logic                  dma_done,
  input  logic                  dma_err,
  output logic                  cmp_start,
  output logic [63:0]           cmp_cfg,
  input  logic                  cmp_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  irq,
  output logic [31:0]           tile_count,
  output logic [31:0]           cycle_count
);

  localparam int unsigned         WW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0]       WAIT_SAT  = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0]       WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

  sched_state_e          state_q, state_d;
  desc_t                 cur_q;
  logic [WW-1:0]         wait_cnt;
  logic                  timed_out;
  logic                  done_q, error_q;
  logic [31:0]           tile_count_q, cycle_count_q;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [DESC_WIDTH-1:0] fifo_rd_data;
  logic [7:0]            head_flags;
  logic                  unused_desc_bits;

  desc_fifo #(
    .WIDTH (DESC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (soft_reset),
    .push      (desc_valid),
    .push_data (desc_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_flags = fifo_rd_data[FLAGS_LSB +: 8];
  // The counter reaching TIMEOUT_CYCLES and the exit to ERR share one edge,
  // so the error appears exactly TIMEOUT_CYCLES cycles after state entry.
  assign timed_out  = (wait_cnt >= WAIT_LAST);

  // Next-state selection; soft_reset overrides everything
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      S_IDLE:     if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (fifo_empty) begin
          state_d = S_DONE;
        end else begin
          fifo_pop = 1'b1;
          state_d  = route_after(head_flags, S_FETCH);
        end
      end
      S_LD_REQ: begin
        if (dma_req_ready)  state_d = S_LD_WAIT;
        else if (timed_out) state_d = S_ERR;
      end
      S_LD_WAIT: begin
        if (dma_err)        state_d = S_ERR;
        else if (dma_done)  state_d = route_after(cur_q.flags, S_LD_WAIT);
        else if (timed_out) state_d = S_ERR;
      end
      S_CMP:      state_d = S_CMP_WAIT;
      S_CMP_WAIT: begin
        if (cmp_done)       state_d = route_after(cur_q.flags, S_CMP_WAIT);
        else if (timed_out) state_d = S_ERR;
      end
      S_ST_REQ: begin
        if (dma_req_ready)  state_d = S_ST_WAIT;
        else if (timed_out) state_d = S_ERR;
      end
      S_ST_WAIT: begin
        if (dma_err)        state_d = S_ERR;
        else if (dma_done)  state_d = S_NEXT;
        else if (timed_out) state_d = S_ERR;
      end
      S_NEXT:     state_d = cur_q.flags[FLAG_LAST] ? S_DONE : S_FETCH;
      S_DONE:     state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (soft_reset) begin
      state_d  = S_IDLE;
      fifo_pop = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Per-state wait counter, cleared on every state change, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wait_cnt <= '0;
    else if (state_d != state_q)  wait_cnt <= '0;
    else if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
  end

  // Current descriptor, loaded when FETCH pops the queue head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cur_q <= '0;
    else if (fifo_pop) cur_q <= desc_t'(fifo_rd_data);
  end

  // Sticky done/error status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else if (soft_reset) begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (state_d == S_DONE)                  done_q <= 1'b1;
      else if (state_q == S_IDLE && start)    done_q <= 1'b0;
      if (state_d == S_ERR)                   error_q <= 1'b1;
    end
  end

  // Tile and busy-cycle counters; cleared by an accepted start, held by soft_reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_count_q  <= '0;
      cycle_count_q <= '0;
    end else if (!soft_reset) begin
      if (state_q == S_IDLE && start) begin
        tile_count_q  <= '0;
        cycle_count_q <= '0;
      end else begin
        if (busy && cycle_count_q != '1) cycle_count_q <= cycle_count_q + 32'd1;
        if (state_q == S_NEXT)           tile_count_q  <= tile_count_q + 32'd1;
      end
    end
  end

  assign busy              = (state_q inside {[S_FETCH:S_NEXT]});
  assign desc_ready        = !fifo_full;
  assign dma_req_valid     = (state_q == S_LD_REQ) || (state_q == S_ST_REQ);
  assign dma_req_write     = (state_q == S_ST_REQ);
  assign dma_req_dram_addr = dma_req_write ? cur_q.dst_addr : cur_q.src_addr;
  assign dma_req_sram_addr = cur_q.sram_addr;
  assign dma_req_len       = cur_q.len;
  assign cmp_start         = (state_q == S_CMP);
  assign cmp_cfg           = {cur_q.cfg_hi, cur_q.cfg_lo};
  assign done              = done_q;
  assign error             = error_q;
  assign irq               = done_q | error_q;
  assign tile_count        = tile_count_q;
  assign cycle_count       = cycle_count_q;

  assign unused_desc_bits  = ^{cur_q.word4, cur_q.word3, cur_q.ctrl_hi,
                               cur_q.ctrl_lo, cur_q.flags[6:3]};

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler with a short timeout for the error path.
module tb_tile_scheduler;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         soft_reset;
  logic         desc_valid;
  logic [255:0] desc_data;
  logic         desc_ready;
  logic         dma_req_valid;
  logic         dma_req_ready;
  logic         dma_req_write;
  logic [31:0]  dma_req_dram_addr;
  logic [15:0]  dma_req_sram_addr;
  logic [15:0]  dma_req_len;
  logic         dma_done;
  logic         dma_err;
  logic         cmp_start;
  logic [63:0]  cmp_cfg;
  logic         cmp_done;
  logic         busy;
  logic         done;
  logic         error;
  logic         irq;
  logic [31:0]  tile_count;
  logic [31:0]  cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  tile_scheduler #(
    .DESC_WIDTH     (256),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .soft_reset        (soft_reset),
    .desc_valid        (desc_valid),
    .desc_data         (desc_data),
    .desc_ready        (desc_ready),
    .dma_req_valid     (dma_req_valid),
    .dma_req_ready     (dma_req_ready),
    .dma_req_write     (dma_req_write),
    .dma_req_dram_addr (dma_req_dram_addr),
    .dma_req_sram_addr (dma_req_sram_addr),
    .dma_req_len       (dma_req_len),
    .dma_done          (dma_done),
    .dma_err           (dma_err),
    .cmp_start         (cmp_start),
    .cmp_cfg           (cmp_cfg),
    .cmp_done          (cmp_done),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .irq               (irq),
    .tile_count        (tile_count),
    .cycle_count       (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_desc(input logic [7:0] flags, input logic [15:0] sram,
                                           input logic [15:0] len, input logic [31:0] src,
                                           input logic [31:0] dst, input logic [31:0] w1,
                                           input logic [31:0] w5);
    logic [255:0] d;
    d          = '0;
    d[23:16]   = flags;
    d[63:32]   = w1;
    d[95:64]   = dst;
    d[191:160] = w5;
    d[207:192] = sram;
    d[223:208] = len;
    d[255:224] = src;
    return d;
  endfunction

  task automatic push(input logic [255:0] d);
    desc_valid = 1'b1;
    desc_data  = d;
    step();
    desc_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_soft_reset();
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
  endtask

  // Bounded wait for done or error
  task automatic wait_end(input int max_cycles);
    int i;
    i = 0;
    while (!(done || error) && i < max_cycles) begin
      step();
      i++;
    end
    chk("wait_end_bound", 64'(done || error), 64'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    soft_reset    = 1'b0;
    desc_valid    = 1'b0;
    desc_data     = '0;
    dma_req_ready = 1'b0;
    dma_done      = 1'b0;
    dma_err       = 1'b0;
    cmp_done      = 1'b0;

    // Reset state
    #12;
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_irq", irq, 0);
    chk("rst_req_valid", dma_req_valid, 0);
    chk("rst_cmp_start", cmp_start, 0);
    chk("rst_tile_count", tile_count, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_dram_addr", dma_req_dram_addr, 0);
    #10 rst_n = 1'b1;
    step();

    // 1: full load/compute/store tile with LAST
    push(mk_desc(8'h87, 16'h0010, 16'd1024, 32'h8000_0000, 32'h0, 32'h1111_2222, 32'h5555_6666));
    pulse_start();
    chk("t1_busy_fetch", busy, 1);
    chk("t1_no_req_fetch", dma_req_valid, 0);
    step();
    chk("t1_ld_valid", dma_req_valid, 1);
    chk("t1_ld_write", dma_req_write, 0);
    chk("t1_ld_addr", dma_req_dram_addr, 64'h8000_0000);
    chk("t1_ld_len", dma_req_len, 1024);
    chk("t1_ld_sram", dma_req_sram_addr, 16'h0010);
    step();
    chk("t1_ld_hold_valid", dma_req_valid, 1);
    chk("t1_ld_hold_addr", dma_req_dram_addr, 64'h8000_0000);
    dma_req_ready = 1'b1;
    step();
    dma_req_ready = 1'b0;
    chk("t1_ld_accepted", dma_req_valid, 0);
    cmp_done = 1'b1;
    step();
    cmp_done = 1'b0;
    chk("t1_stray_cmp_done", cmp_start, 0);
    chk("t1_stray_busy", busy, 1);
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
    chk("t1_cmp_start", cmp_start, 1);
    chk("t1_cmp_cfg", cmp_cfg, 64'h5555_6666_1111_2222);
    step();
    chk("t1_cmp_start_once", cmp_start, 0);
    cmp_done = 1'b1;
    step();
    cmp_done = 1'b0;
    chk("t1_st_valid", dma_req_valid, 1);
    chk("t1_st_write", dma_req_write, 1);
    chk("t1_st_addr", dma_req_dram_addr, 0);
    dma_req_ready = 1'b1;
    step();
    dma_req_ready = 1'b0;
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
    chk("t1_next_tile_count", tile_count, 0);
    step();
    chk("t1_done", done, 1);
    chk("t1_irq", irq, 1);
    chk("t1_busy_clear", busy, 0);
    chk("t1_tile_count", tile_count, 1);
    chk("t1_cycle_count", cycle_count, 10);
    step();
    chk("t1_done_sticky", done, 1);

    // 2: queue overflow, no LAST, drains to empty
    for (int i = 0; i < 4; i++) push(mk_desc(8'h00, 16'h0, 16'h0, 32'h0, 32'h0, 32'h0, 32'h0));
    chk("t2_full_ready", desc_ready, 0);
    push(mk_desc(8'h80, 16'h0, 16'h0, 32'h0, 32'h0, 32'h0, 32'h0));
    pulse_start();
    chk("t2_done_cleared", done, 0);
    chk("t2_busy", busy, 1);
    wait_end(40);
    chk("t2_tile_count", tile_count, 4);
    chk("t2_cycle_count", cycle_count, 9);
    chk("t2_no_error", error, 0);
    chk("t2_ready_empty", desc_ready, 1);
    step();

    // 3: dma_err beats dma_done in LD_WAIT
    push(mk_desc(8'h07, 16'h0, 16'd64, 32'h1000, 32'h2000, 32'h0, 32'h0));
    pulse_start();
    step();
    dma_req_ready = 1'b1;
    step();
    dma_req_ready = 1'b0;
    dma_done = 1'b1;
    dma_err  = 1'b1;
    step();
    dma_done = 1'b0;
    dma_err  = 1'b0;
    chk("t3_error", error, 1);
    chk("t3_irq", irq, 1);
    chk("t3_busy", busy, 0);
    chk("t3_no_cmp", cmp_start, 0);
    chk("t3_tile_count", tile_count, 0);
    chk("t3_done", done, 0);
    step();
    chk("t3_no_cmp_idle", cmp_start, 0);
    chk("t3_error_sticky", error, 1);
    pulse_soft_reset();
    chk("t3_error_cleared", error, 0);
    chk("t3_irq_cleared", irq, 0);

    // 4: compute timeout
    push(mk_desc(8'h02, 16'h0, 16'h0, 32'h0, 32'h0, 32'h0000_000A, 32'h0000_000B));
    pulse_start();
    step();
    chk("t4_cmp_start", cmp_start, 1);
    chk("t4_cmp_cfg", cmp_cfg, 64'h0000_000B_0000_000A);
    step();
    for (int i = 0; i < 15; i++) step();
    chk("t4_no_error_yet", error, 0);
    chk("t4_busy_waiting", busy, 1);
    step();
    chk("t4_timeout_error", error, 1);
    chk("t4_timeout_busy", busy, 0);
    step();
    pulse_soft_reset();

    // 5: soft_reset during ST_WAIT, late dma_done
    push(mk_desc(8'h00, 16'h0, 16'h0, 32'h0, 32'h0, 32'h0, 32'h0));
    push(mk_desc(8'h04, 16'h0020, 16'd64, 32'h0, 32'h1234_5678, 32'h0, 32'h0));
    push(mk_desc(8'h00, 16'h0, 16'h0, 32'h0, 32'h0, 32'h0, 32'h0));
    pulse_start();
    step();
    step();
    step();
    chk("t5_st_valid", dma_req_valid, 1);
    chk("t5_st_write", dma_req_write, 1);
    chk("t5_st_addr", dma_req_dram_addr, 64'h1234_5678);
    chk("t5_st_len", dma_req_len, 64);
    dma_req_ready = 1'b1;
    step();
    dma_req_ready = 1'b0;
    pulse_soft_reset();
    chk("t5_sr_busy", busy, 0);
    chk("t5_sr_ready", desc_ready, 1);
    chk("t5_sr_valid", dma_req_valid, 0);
    chk("t5_sr_tile_count", tile_count, 1);
    chk("t5_sr_cycle_count", cycle_count, 4);
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
    chk("t5_late_busy", busy, 0);
    chk("t5_late_tile_count", tile_count, 1);
    chk("t5_late_done", done, 0);
    pulse_start();
    step();
    chk("t5_flushed_done", done, 1);
    chk("t5_flushed_tiles", tile_count, 0);
    chk("t5_flushed_cycles", cycle_count, 1);
    step();

    // 6: extra start while busy, LAST-only descriptor
    push(mk_desc(8'h80, 16'h0, 16'h0, 32'h0, 32'h0, 32'h0, 32'h0));
    pulse_start();
    chk("t6_busy", busy, 1);
    chk("t6_cycle_start", cycle_count, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_no_req", dma_req_valid, 0);
    chk("t6_no_cmp", cmp_start, 0);
    chk("t6_start_ignored", cycle_count, 1);
    step();
    chk("t6_done", done, 1);
    chk("t6_irq", irq, 1);
    chk("t6_tile_count", tile_count, 1);
    chk("t6_cycle_count", cycle_count, 2);
    chk("t6_no_req_done", dma_req_valid, 0);
    step();
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
Sequences per-tile work for the MobileViT accelerator. It buffers descriptors pushed through the control registers, then for each descriptor issues a DMA load, a compute start and a DMA store in order. Between descriptors it maintains the busy/done/error status, the tile counter and the cycle counter, and it raises a level interrupt. It sits between the register block (descriptor push, START, soft reset) and the DMA engine and compute array.

Parameters:
DESC_WIDTH, 256, descriptor width (8 x 32-bit words, word0 in bits [31:0]).
FIFO_DEPTH, 4, descriptor queue entries (power of 2, minimum 2).
TIMEOUT_CYCLES, 65535, maximum wait for any done/ack before the error path.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse from the CONTROL[0] write
soft_reset  in  1  single-cycle pulse from CONTROL[1]; synchronous flush
desc_valid  in  1  descriptor push strobe
desc_data  in  DESC_WIDTH  descriptor words 0..7
desc_ready  out  1  queue not full
dma_req_valid  out  1  DMA request valid
dma_req_ready  in  1  DMA accepts request
dma_req_write  out  1  0 = load (DRAM to SRAM), 1 = store
dma_req_dram_addr  out  32  DRAM byte address
dma_req_sram_addr  out  16  SRAM word address
dma_req_len  out  16  byte length
dma_done  in  1  pulse: current DMA request finished
dma_err  in  1  pulse: DMA response error (RRESP/BRESP not OKAY)
cmp_start  out  1  single-cycle compute start pulse
cmp_cfg  out  64  {word5, word1} of the current descriptor
cmp_done  in  1  pulse: compute finished
busy  out  1  scheduler active
done  out  1  sticky; cleared by start or soft_reset
error  out  1  sticky; cleared by soft_reset only
irq  out  1  level; equals done | error
tile_count  out  32  descriptors completed since the last start
cycle_count  out  32  cycles spent busy since the last start

Behaviour:
- Reset (rst_n low): FSM goes to IDLE and the queue is emptied. All outputs are 0 except desc_ready, which is 1.
- Queue: synchronous FIFO with push when desc_valid & desc_ready.
  - A push while the queue is full is dropped; desc_ready stays 0.
  - Pushes are accepted in any state.
- Descriptor fields:
  - word0[23:16] flags: bit0 LOAD, bit1 COMPUTE, bit2 STORE, bit7 LAST.
  - word6[15:0] sram_addr; word6[31:16] len.
  - word7 is the source DRAM address; word2 is the destination DRAM address.
- FSM states: IDLE, FETCH, LD_REQ, LD_WAIT, CMP, CMP_WAIT, ST_REQ, ST_WAIT, NEXT, DONE, ERR.
  - IDLE: on start, go to FETCH. tile_count and cycle_count clear to 0, done clears, busy is set next cycle. A start while busy is ignored.
  - FETCH: if the queue is empty, go to DONE. Otherwise pop into the current-descriptor register (1 cycle), then go to LD_REQ if LOAD is set, else CMP if COMPUTE is set, else ST_REQ if STORE is set, else NEXT.
  - LD_REQ / ST_REQ: hold dma_req_valid with stable fields until dma_req_ready, then go to the matching WAIT state. dma_req_write is 0 for LD and 1 for ST.
  - LD_WAIT: on dma_done, go to CMP or ST_REQ or NEXT per the flags.
  - CMP: cmp_start high for exactly 1 cycle, then CMP_WAIT.
  - CMP_WAIT: on cmp_done, go to ST_REQ or NEXT per the flags.
  - ST_WAIT: on dma_done, go to NEXT.
  - NEXT: tile_count increments by 1 (wraps at 2^32). Go to DONE if LAST is set, else FETCH.
  - DONE: done = 1, busy = 0, then IDLE.
  - ERR: error = 1, busy = 0, then IDLE. Descriptors remaining in the queue are kept.
- Timeout and DMA errors:
  - A per-state wait counter resets on every state entry. In any REQ or WAIT state it saturates at TIMEOUT_CYCLES and then forces ERR.
  - dma_err in LD_WAIT or ST_WAIT goes to ERR; it takes priority over a simultaneous dma_done.
- Stray pulses: dma_done and cmp_done outside their WAIT state are ignored.
- cycle_count increments every cycle busy = 1 and saturates at 0xFFFFFFFF.
- soft_reset: synchronous, takes priority over every other input.
  - Same cycle: FSM goes to IDLE, the queue is flushed, done/error/busy/dma_req_valid clear.
  - The counters hold their values.
  - If a DMA request is outstanding, a later dma_done is ignored.
- Latency: start to first dma_req_valid is 3 cycles (IDLE, FETCH, LD_REQ) when the queue is non-empty.

Decomposition:
- accelerator_common_pkg holds:
  - the sched_state_e enum;
  - the descriptor-flag bit positions (FLAG_LOAD=0, FLAG_COMPUTE=1, FLAG_STORE=2, FLAG_LAST=7);
  - the word-index localparams for the descriptor fields;
  - a packed desc_t struct.
- One sub-module, desc_fifo: parameterised width/depth synchronous FIFO with full/empty and asynchronous active-low reset. Reused by the top level.

Test Plan:
- Push 1 descriptor (flags 0x87, len 1024, src 0x8000_0000, dst 0), then start → load request at cycle 3 with addr 0x8000_0000 and len 1024; cmp_start once after dma_done; store to 0x0. Ends with done=1, irq=1, tile_count=1.
- Push 5 descriptors with FIFO_DEPTH=4 → the 5th push sees desc_ready=0 and is dropped. Start with no LAST flags → 4 tiles complete, then empty queue → done, tile_count=4.
- dma_err asserted on the same cycle as dma_done in LD_WAIT → ERR, error=1, irq=1, no cmp_start, tile_count=0.
- Withhold cmp_done with TIMEOUT_CYCLES=16 → error=1 exactly 16 cycles after CMP_WAIT entry.
- soft_reset during ST_WAIT, then a late dma_done → idle, busy=0, queue empty, desc_ready=1, tile_count unchanged, the late pulse is ignored.
- start pulse while busy, and flags 0x80 (LAST only) → the extra start has no effect; the no-op descriptor completes with tile_count=1 and no DMA or compute activity.
